sdram_frame_writer: RTL and testbench
=====================================

// Module: sdram_frame_writer
// PURPOSE
// - Write side of the double-buffered background framebuffer in SDRAM. Accepts 16-bit words (two 8-bit palette indices) over valid/ready.
// - Writes each word into the back buffer using the same req/ack SDRAM handshake the line fetcher uses for reads.
// - Toggles frame_flip at a frame boundary so the line fetcher displays the completed buffer.
// PARAMETERS
// - WORDS_PER_LINE  320        words per line (640 px / 2)
// - LINES           480        lines per frame
// - BASE_A          20'h9CD20  buffer A base word address
// - BASE_B          20'hC2520  buffer B base word address
// - ADDR_W          25         SDRAM address width
// PORTS
// - clock        in   1       system clock
// - reset        in   1       synchronous, active-high
// - new_frame    in   1       1-cycle pulse at VGA frame start
// - pix_valid    in   1       source word valid
// - pix_sof      in   1       with pix_valid: word is pixel (0,0) of a frame
// - pix_data     in   16      [15:8] even px index, [7:0] odd px index
// - pix_ready    out  1       writer accepts a word this cycle
// - sdram_addr   out  ADDR_W  word address, held stable while sdram_wr=1
// - sdram_wdata  out  16      write data, held stable while sdram_wr=1
// - sdram_wr     out  1       write request
// - sdram_ac     in   1       controller acknowledge (level)
// - sdram_wait   in   1       controller busy; no new request may start
// - frame_flip   out  1       1: display BASE_A / write BASE_B; 0: display BASE_B / write BASE_A
// - frame_done   out  1       back buffer full, waiting for flip
// - busy         out  1       SDRAM transaction in progress
// BEHAVIOUR
// - Reset: state=IDLE; offset=0; frame_flip=0; frame_done=0; sdram_wr=0; busy=0; pix_ready=0 for that cycle; sdram_addr/wdata=0.
// - Address: sdram_addr = (frame_flip ? BASE_B : BASE_A) + offset. offset is a running counter 0..WORDS_PER_LINE*LINES-1. No multiplier.
// - pix_ready = (state==IDLE) & ~sdram_wait & ~frame_done. This is combinational.
// - FSM IDLE: on pix_valid&pix_ready, latch pix_data into sdram_wdata.
//   - If pix_sof=1, offset<=0 first; the word is written at offset 0.
//   - Next state REQ.
// - FSM REQ: sdram_wr=1, busy=1; stay until sdram_ac=1, then go to REL.
// - FSM REL: sdram_wr=0, busy=1; wait for sdram_ac=0.
//   - Then, if offset==WORDS_PER_LINE*LINES-1: offset<=0, frame_done<=1, go to IDLE.
//   - Otherwise offset<=offset+1 and go to IDLE.
// - Throughput: at most 1 word per 3 cycles, plus controller ack latency. Accept-to-sdram_wr latency is 1 cycle.
// - Flip: new_frame while frame_done=1 toggles frame_flip and clears frame_done in the same edge. The next accepted word targets the new back buffer.
// - new_frame while frame_done=0 is ignored; frame_flip holds, so a partial frame is never displayed.
// - Completion and new_frame on the same cycle: no flip; the flip happens at the following new_frame.
// - pix_sof mid-frame: resynchronises offset to 0 and keeps the same back buffer. Words already written are overwritten.
// - sdram_wait only gates entry from IDLE. An in-flight REQ/REL completes regardless.
// - Reset mid-transaction: sdram_wr drops on the next edge. The controller must tolerate request withdrawal.
// CONFIGURATION
// - FRAME_CLEAR_EN defined: adds inputs clear_req (1) and clear_data (16), and state CLEAR.
//   - clear_req in IDLE with frame_done=0 enters CLEAR, which fills the whole back buffer with clear_data. pix_ready=0 throughout.
//   - Each word uses the same REQ/REL handshake. At the end, frame_done<=1 and offset<=0.
// - FRAME_CLEAR_EN undefined: no ports, no CLEAR state; the fill is done by the pixel source.
// TESTING
// - Reset, then WORDS_PER_LINE=4, LINES=2, ack 2 cycles after req.
//   - 8 words accepted -> addresses BASE_A+0..7, data matches, frame_done=1, pix_ready=0.
// - frame_done=1, pulse new_frame -> frame_flip=1 and frame_done=0 next cycle. The next word is written at BASE_B+0.
// - new_frame pulse after 3 of 8 words -> frame_flip unchanged, and the 4th word goes to BASE_A+3.
// - sdram_wait=1 held 10 cycles in IDLE -> pix_ready=0 and sdram_wr=0. Wait asserted during REQ -> that write still completes.
// - pix_sof on the 5th word -> written at BASE_A+0. Offset then continues 1, 2, ...
// - Reset asserted while in REQ -> sdram_wr=0, frame_flip=0 and offset=0 after one edge.
//   - With FRAME_CLEAR_EN: clear_req, clear_data=16'h0101 -> 8 writes of 16'h0101, then frame_done=1.

Source files
------------

// File: rtl/sdram_frame_writer.sv
// Back-buffer writer: streams 16-bit palette words into SDRAM over a req/ack handshake
// and flips the display/write buffers on new_frame once a full frame has landed.
// Optional FRAME_CLEAR_EN adds a hardware fill of the back buffer with a constant word.
module sdram_frame_writer #(
  parameter int unsigned WORDS_PER_LINE = 320,
  parameter int unsigned LINES          = 480,
  parameter logic [19:0] BASE_A         = 20'h9CD20,
  parameter logic [19:0] BASE_B         = 20'hC2520,
  parameter int unsigned ADDR_W         = 25
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_frame,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [15:0]       pix_data,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [15:0]       sdram_wdata,
  output logic              sdram_wr,
  input  logic              sdram_ac,
  input  logic              sdram_wait,
`ifdef FRAME_CLEAR_EN
  input  logic              clear_req,
  input  logic [15:0]       clear_data,
`endif
  output logic              frame_flip,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned FRAME_WORDS = WORDS_PER_LINE * LINES;
  localparam int unsigned OFF_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_WORDS - 1);

`ifdef FRAME_CLEAR_EN
  typedef enum logic [1:0] {IDLE, REQ, REL, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
`endif

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic               flip_d, done_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [15:0]        wdata_d;
  logic [19:0]        base;
  logic               clearing_q, clearing_d;

`ifdef FRAME_CLEAR_EN
  assign pix_ready = (state_q == IDLE) & ~sdram_wait & ~frame_done & ~reset & ~clear_req;
`else
  assign pix_ready = (state_q == IDLE) & ~sdram_wait & ~frame_done & ~reset;
  assign clearing_q = 1'b0;
`endif

  assign base = frame_flip ? BASE_B : BASE_A;

  // Next-state, offset and flip bookkeeping
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    flip_d     = frame_flip;
    done_d     = frame_done;
    addr_d     = sdram_addr;
    wdata_d    = sdram_wdata;
    clearing_d = clearing_q;

    // Only a completed frame may be shown; completion and accept never overlap this.
    if (new_frame && frame_done) begin
      flip_d = ~frame_flip;
      done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
`ifdef FRAME_CLEAR_EN
        if (clear_req && !frame_done) begin
          offset_d   = '0;
          clearing_d = 1'b1;
          state_d    = CLEAR;
        end else
`endif
        if (pix_valid && pix_ready) begin
          wdata_d  = pix_data;
          offset_d = pix_sof ? '0 : offset_q;
          addr_d   = ADDR_W'(base) + ADDR_W'(offset_d);
          state_d  = REQ;
        end
      end
`ifdef FRAME_CLEAR_EN
      CLEAR: begin
        if (!sdram_wait) begin
          wdata_d = clear_data;
          addr_d  = ADDR_W'(base) + ADDR_W'(offset_q);
          state_d = REQ;
        end
      end
`endif
      REQ: begin
        if (sdram_ac) state_d = REL;
      end
      REL: begin
        if (!sdram_ac) begin
          if (offset_q == LAST_OFF) begin
            offset_d   = '0;
            done_d     = 1'b1;
            clearing_d = 1'b0;
            state_d    = IDLE;
          end else begin
            offset_d = offset_q + OFF_W'(1);
`ifdef FRAME_CLEAR_EN
            state_d  = clearing_q ? CLEAR : IDLE;
`else
            state_d  = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      frame_flip  <= 1'b0;
      frame_done  <= 1'b0;
      sdram_addr  <= '0;
      sdram_wdata <= '0;
      sdram_wr    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      frame_flip  <= flip_d;
      frame_done  <= done_d;
      sdram_addr  <= addr_d;
      sdram_wdata <= wdata_d;
      sdram_wr    <= (state_d == REQ);
      busy        <= (state_d == REQ) || (state_d == REL);
    end
  end

`ifdef FRAME_CLEAR_EN
  always_ff @(posedge clock) begin
    if (reset) clearing_q <= 1'b0;
    else       clearing_q <= clearing_d;
  end
`else
  logic unused_clearing;
  assign unused_clearing = clearing_d;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer with a 4x2 frame and a 2-cycle-ack controller model.
module tb_sdram_frame_writer;

  localparam logic [24:0] A0 = 25'h009CD20;
  localparam logic [24:0] B0 = 25'h00C2520;

  logic        clock = 1'b0;
  logic        reset, new_frame, pix_valid, pix_sof, pix_ready;
  logic [15:0] pix_data, sdram_wdata;
  logic [24:0] sdram_addr;
  logic        sdram_wr, sdram_ac, sdram_wait, frame_flip, frame_done, busy;
`ifdef FRAME_CLEAR_EN
  logic        clear_req;
  logic [15:0] clear_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [24:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int ack_cnt = 0;

  sdram_frame_writer #(.WORDS_PER_LINE(4), .LINES(2)) dut (
    .clock(clock), .reset(reset), .new_frame(new_frame),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata), .sdram_wr(sdram_wr),
    .sdram_ac(sdram_ac), .sdram_wait(sdram_wait),
`ifdef FRAME_CLEAR_EN
    .clear_req(clear_req), .clear_data(clear_data),
`endif
    .frame_flip(frame_flip), .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  // Controller: ack two cycles after request, drop ack once request withdrawn.
  always @(posedge clock) begin
    if (reset) begin
      sdram_ac <= 1'b0;
      ack_cnt  <= 0;
    end else if (sdram_wr && !sdram_ac) begin
      if (ack_cnt == 1) begin
        sdram_ac <= 1'b1;
        ack_cnt  <= 0;
        wr_addr.push_back(sdram_addr);
        wr_data.push_back(sdram_wdata);
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else if (!sdram_wr) begin
      sdram_ac <= 1'b0;
      ack_cnt  <= 0;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    new_frame = 1'b0; sdram_wait = 1'b0;
`ifdef FRAME_CLEAR_EN
    clear_req = 1'b0; clear_data = '0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send(input logic [15:0] d, input logic sof);
    int n = 0;
    @(negedge clock);
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    while (!pix_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout pix_ready=%b expected 1", pix_ready);
    end
    @(negedge clock);
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%b expected 0", busy);
    end
  endtask

  task automatic check_write(input int idx, input logic [24:0] ea, input logic [15:0] ed);
    checks++;
    if (idx >= wr_addr.size()) begin
      errors++;
      $display("FAIL write%0d_missing got %0d writes", idx, wr_addr.size());
    end else if (wr_addr[idx] !== ea || wr_data[idx] !== ed) begin
      errors++;
      $display("FAIL write%0d addr=%h data=%h expected addr=%h data=%h",
               idx, wr_addr[idx], wr_data[idx], ea, ed);
    end
  endtask

  task automatic fill_frame(input logic [15:0] base_d);
    int n = 0;
    for (int i = 0; i < 8; i++) send(base_d + 16'(i), 1'b0);
    while (!frame_done && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    new_frame = 1'b0; sdram_wait = 1'b0;
`ifdef FRAME_CLEAR_EN
    clear_req = 1'b0; clear_data = '0;
`endif
    repeat (2) @(negedge clock);
    checks++;
    if ({sdram_wr, busy, frame_flip, frame_done, pix_ready} !== 5'b0 ||
        sdram_addr !== '0 || sdram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state wr=%b busy=%b flip=%b done=%b rdy=%b addr=%h wd=%h expected all 0",
               sdram_wr, busy, frame_flip, frame_done, pix_ready, sdram_addr, sdram_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset pix_ready=%b expected 1", pix_ready);
    end
  endtask

  // Full frame; new_frame held across completion must not flip.
  task automatic test_frame();
    int n = 0;
    do_reset();
    for (int i = 0; i < 7; i++) send(16'hA000 + 16'(i), 1'b0);
    send(16'hA007, 1'b0);
    new_frame = 1'b1;
    while (!frame_done && n < 50) begin
      @(negedge clock);
      n++;
    end
    new_frame = 1'b0;
    for (int i = 0; i < 8; i++) check_write(i, A0 + 25'(i), 16'hA000 + 16'(i));
    checks++;
    if (frame_done !== 1'b1 || pix_ready !== 1'b0 || frame_flip !== 1'b0) begin
      errors++;
      $display("FAIL frame_complete done=%b rdy=%b flip=%b expected 1 0 0",
               frame_done, pix_ready, frame_flip);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (frame_flip !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL no_late_flip flip=%b done=%b expected 0 1", frame_flip, frame_done);
    end
  endtask

  task automatic test_flip();
    do_reset();
    fill_frame(16'h1100);
    new_frame = 1'b1;
    @(negedge clock);
    new_frame = 1'b0;
    checks++;
    if (frame_flip !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL flip flip=%b done=%b expected 1 0", frame_flip, frame_done);
    end
    wr_addr.delete(); wr_data.delete();
    send(16'hBEEF, 1'b0);
    wait_idle();
    check_write(0, B0, 16'hBEEF);
  endtask

  task automatic test_partial_flip();
    do_reset();
    for (int i = 0; i < 3; i++) send(16'h2200 + 16'(i), 1'b0);
    wait_idle();
    new_frame = 1'b1;
    @(negedge clock);
    new_frame = 1'b0;
    checks++;
    if (frame_flip !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL partial_flip flip=%b done=%b expected 0 0", frame_flip, frame_done);
    end
    send(16'h2203, 1'b0);
    wait_idle();
    check_write(3, A0 + 25'd3, 16'h2203);
  endtask

  task automatic test_wait();
    int bad = 0;
    do_reset();
    @(negedge clock);
    sdram_wait = 1'b1; pix_valid = 1'b1; pix_data = 16'h3333; pix_sof = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (pix_ready !== 1'b0 || sdram_wr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL wait_gate bad_cycles=%0d writes=%0d expected 0 0", bad, wr_addr.size());
    end
    sdram_wait = 1'b0;
    @(negedge clock);
    pix_valid = 1'b0;
    sdram_wait = 1'b1;
    checks++;
    if (sdram_wr !== 1'b1) begin
      errors++;
      $display("FAIL wr_latency sdram_wr=%b expected 1", sdram_wr);
    end
    wait_idle();
    check_write(0, A0, 16'h3333);
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_after pix_ready=%b expected 0", pix_ready);
    end
    sdram_wait = 1'b0;
  endtask

  task automatic test_sof();
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h4400 + 16'(i), 1'b0);
    send(16'h4404, 1'b1);
    send(16'h4405, 1'b0);
    send(16'h4406, 1'b0);
    wait_idle();
    check_write(3, A0 + 25'd3, 16'h4403);
    check_write(4, A0, 16'h4404);
    check_write(5, A0 + 25'd1, 16'h4405);
    check_write(6, A0 + 25'd2, 16'h4406);
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_frame(16'h5500);
    new_frame = 1'b1;
    @(negedge clock);
    new_frame = 1'b0;
    send(16'h5555, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (sdram_wr !== 1'b0 || frame_flip !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid wr=%b flip=%b busy=%b done=%b expected 0 0 0 0",
               sdram_wr, frame_flip, busy, frame_done);
    end
    reset = 1'b0;
    wr_addr.delete(); wr_data.delete();
    send(16'h6666, 1'b0);
    wait_idle();
    check_write(0, A0, 16'h6666);
  endtask

`ifdef FRAME_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    int rdy_bad = 0;
    do_reset();
    clear_data = 16'h0101;
    clear_req  = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    while (!frame_done && n < 200) begin
      if (pix_ready !== 1'b0) rdy_bad++;
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 8; i++) check_write(i, A0 + 25'(i), 16'h0101);
    checks++;
    if (frame_done !== 1'b1 || rdy_bad != 0 || wr_addr.size() != 8) begin
      errors++;
      $display("FAIL clear_end done=%b rdy_bad=%0d writes=%0d expected 1 0 8",
               frame_done, rdy_bad, wr_addr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_flip();
    test_partial_flip();
    test_wait();
    test_sof();
    test_reset_mid();
`ifdef FRAME_CLEAR_EN
    test_clear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
